// File: rtl/cp0_tlb_pkg.sv
// cp0_tlb_pkg: shared definitions for the CP0 TLB-management unit.
// Holds CP0 register numbers, TLB command encodings, FSM states and the EntryLo layout.
package cp0_tlb_pkg;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_WAIT,
        ST_READ,
        ST_WRITE,
        ST_DRAIN
    } tlb_state_e;

    // Same bit order as EntryLo[25:0]: PFN, C, D, V, G.
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } entrylo_t;

    function automatic entrylo_t lo_unpack(input logic [25:0] w);
        return entrylo_t'(w);
    endfunction

    function automatic logic [31:0] lo_pack(input entrylo_t e);
        return {6'd0, e};
    endfunction

endpackage

// File: rtl/cp0_random.sv
// cp0_random: Random/Wired counter pair for TLBWR replacement selection.
// Ports: i_clk, i_reset (sync, active high), i_wired_we/i_wired_wdata (mtc0 Wired), o_random, o_wired.
module cp0_random
    import cp0_tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wired_we,
    input  logic [IDXW-1:0] i_wired_wdata,
    output logic [IDXW-1:0] o_random,
    output logic [IDXW-1:0] o_wired
);

    localparam logic [IDXW-1:0] TOP = IDXW'(TLBNUM - 1);

    logic [IDXW-1:0] r_random;
    logic [IDXW-1:0] r_wired;

    // Random walks down to Wired, then wraps back to the top entry,
    // so wired entries below Wired are never chosen by TLBWR.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_random <= TOP;
            r_wired  <= '0;
        end else if (i_wired_we) begin
            r_wired  <= i_wired_wdata;
            r_random <= TOP;
        end else if (r_random == r_wired) begin
            r_random <= TOP;
        end else begin
            r_random <= r_random - IDXW'(1);
        end
    end

    assign o_random = r_random;
    assign o_wired  = r_wired;

endmodule

// File: rtl/cp0_tlb_unit.sv
// cp0_tlb_unit: CP0 TLB registers (Index/Random/Wired/EntryHi/EntryLo0/1) and TLBP/TLBR/TLBWI/TLBWR sequencer.
// Ports: cmd_* handshake with WB, mtc0/mfc0 access, exc_tlb capture, s_* search, r_* read, we/w_* write ports.
module cp0_tlb_unit
    import cp0_tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cmd_valid,
    input  logic [1:0]      i_cmd_op,
    output logic            o_cmd_ready,
    output logic            o_cmd_done,
    input  logic            i_flush,
    input  logic            i_mtc0_we,
    input  logic [4:0]      i_cp0_waddr,
    input  logic [31:0]     i_cp0_wdata,
    input  logic [4:0]      i_cp0_raddr,
    output logic [31:0]     o_cp0_rdata,
    input  logic            i_exc_tlb,
    input  logic [31:0]     i_exc_badvaddr,
    output logic            o_s_req,
    output logic [18:0]     o_s_vpn2,
    output logic [7:0]      o_s_asid,
    input  logic            i_s_resp_valid,
    input  logic            i_s_found,
    input  logic [IDXW-1:0] i_s_index,
    output logic [IDXW-1:0] o_r_index,
    input  logic [18:0]     i_r_vpn2,
    input  logic [7:0]      i_r_asid,
    input  logic            i_r_g,
    input  logic [19:0]     i_r_pfn0,
    input  logic [2:0]      i_r_c0,
    input  logic            i_r_d0,
    input  logic            i_r_v0,
    input  logic [19:0]     i_r_pfn1,
    input  logic [2:0]      i_r_c1,
    input  logic            i_r_d1,
    input  logic            i_r_v1,
    output logic            o_we,
    output logic [IDXW-1:0] o_w_index,
    output logic [18:0]     o_w_vpn2,
    output logic [7:0]      o_w_asid,
    output logic            o_w_g,
    output logic [19:0]     o_w_pfn0,
    output logic [2:0]      o_w_c0,
    output logic            o_w_d0,
    output logic            o_w_v0,
    output logic [19:0]     o_w_pfn1,
    output logic [2:0]      o_w_c1,
    output logic            o_w_d1,
    output logic            o_w_v1
);

    tlb_state_e      r_state;
    logic            r_cmd_ready;
    logic [1:0]      r_op;
    logic            r_p;
    logic [IDXW-1:0] r_index;
    logic [18:0]     r_vpn2;
    logic [7:0]      r_asid;
    entrylo_t        r_lo0;
    entrylo_t        r_lo1;

    tlb_state_e      w_next;
    logic [IDXW-1:0] w_random;
    logic [IDXW-1:0] w_wired;
    logic            w_accept;
    logic            w_probe_upd;
    logic            w_read_upd;
    logic            w_wr_index;
    logic            w_wr_hi;
    logic            w_wr_lo0;
    logic            w_wr_lo1;
    logic            w_wr_wired;
    logic            w_unused_badvaddr;

    assign w_wr_index = i_mtc0_we && (i_cp0_waddr == CP0_INDEX);
    assign w_wr_hi    = i_mtc0_we && (i_cp0_waddr == CP0_ENTRYHI);
    assign w_wr_lo0   = i_mtc0_we && (i_cp0_waddr == CP0_ENTRYLO0);
    assign w_wr_lo1   = i_mtc0_we && (i_cp0_waddr == CP0_ENTRYLO1);
    assign w_wr_wired = i_mtc0_we && (i_cp0_waddr == CP0_WIRED);

    // The page-offset bits of the faulting address carry no TLB state.
    assign w_unused_badvaddr = ^i_exc_badvaddr[12:0];

    cp0_random #(
        .TLBNUM(TLBNUM)
    ) u_random (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_wired_we   (w_wr_wired),
        .i_wired_wdata(i_cp0_wdata[IDXW-1:0]),
        .o_random     (w_random),
        .o_wired      (w_wired)
    );

    // A flush in the same cycle kills the state's side effects, so these
    // strobes are decoded from state and live inputs rather than registered.
    assign w_accept    = (r_state == ST_IDLE) && i_cmd_valid && !i_flush;
    assign o_s_req     = (r_state == ST_PROBE) && !i_flush;
    assign w_probe_upd = (r_state == ST_WAIT) && i_s_resp_valid && !i_flush;
    assign w_read_upd  = (r_state == ST_READ) && !i_flush;
    assign o_we        = (r_state == ST_WRITE) && !i_flush;
    assign o_cmd_done  = w_probe_upd || w_read_upd || o_we;
    assign o_cmd_ready = r_cmd_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (i_cmd_op)
                        OP_TLBP: w_next = ST_PROBE;
                        OP_TLBR: w_next = ST_READ;
                        default: w_next = ST_WRITE;
                    endcase
                end
            end
            ST_PROBE: w_next = i_flush ? ST_IDLE : ST_WAIT;
            // A response arriving with the flush is consumed here, so
            // only a still-outstanding search needs draining.
            ST_WAIT: begin
                if (i_s_resp_valid) begin
                    w_next = ST_IDLE;
                end else if (i_flush) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_READ:  w_next = ST_IDLE;
            ST_WRITE: w_next = ST_IDLE;
            ST_DRAIN: begin
                if (i_s_resp_valid) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_op        <= OP_TLBP;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == ST_IDLE);
            if (w_accept) begin
                r_op <= i_cmd_op;
            end
        end
    end

    // Per-field priority: exception > command update > mtc0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p     <= 1'b0;
            r_index <= '0;
            r_vpn2  <= '0;
            r_asid  <= '0;
            r_lo0   <= '0;
            r_lo1   <= '0;
        end else begin
            if (w_probe_upd) begin
                r_p <= !i_s_found;
                if (i_s_found) begin
                    r_index <= i_s_index;
                end
            end else if (w_wr_index) begin
                r_index <= i_cp0_wdata[IDXW-1:0];
            end

            if (i_exc_tlb) begin
                r_vpn2 <= i_exc_badvaddr[31:13];
            end else if (w_read_upd) begin
                r_vpn2 <= i_r_vpn2;
            end else if (w_wr_hi) begin
                r_vpn2 <= i_cp0_wdata[31:13];
            end

            if (w_read_upd) begin
                r_asid <= i_r_asid;
            end else if (w_wr_hi) begin
                r_asid <= i_cp0_wdata[7:0];
            end

            // The TLB keeps one G per entry; it lands in both EntryLo copies.
            if (w_read_upd) begin
                r_lo0 <= '{pfn: i_r_pfn0, c: i_r_c0, d: i_r_d0,
                           v: i_r_v0, g: i_r_g};
                r_lo1 <= '{pfn: i_r_pfn1, c: i_r_c1, d: i_r_d1,
                           v: i_r_v1, g: i_r_g};
            end else begin
                if (w_wr_lo0) begin
                    r_lo0 <= lo_unpack(i_cp0_wdata[25:0]);
                end
                if (w_wr_lo1) begin
                    r_lo1 <= lo_unpack(i_cp0_wdata[25:0]);
                end
            end
        end
    end

    always_comb begin
        o_cp0_rdata = '0;
        case (i_cp0_raddr)
            CP0_INDEX:    o_cp0_rdata = {r_p, {(31-IDXW){1'b0}}, r_index};
            CP0_RANDOM:   o_cp0_rdata = {{(32-IDXW){1'b0}}, w_random};
            CP0_ENTRYLO0: o_cp0_rdata = lo_pack(r_lo0);
            CP0_ENTRYLO1: o_cp0_rdata = lo_pack(r_lo1);
            CP0_WIRED:    o_cp0_rdata = {{(32-IDXW){1'b0}}, w_wired};
            CP0_ENTRYHI:  o_cp0_rdata = {r_vpn2, 5'd0, r_asid};
            default:      o_cp0_rdata = '0;
        endcase
    end

    assign o_s_vpn2  = r_vpn2;
    assign o_s_asid  = r_asid;
    assign o_r_index = r_index;

    assign o_w_index = (r_op == OP_TLBWR) ? w_random : r_index;
    assign o_w_vpn2  = r_vpn2;
    assign o_w_asid  = r_asid;
    assign o_w_g     = r_lo0.g & r_lo1.g;
    assign o_w_pfn0  = r_lo0.pfn;
    assign o_w_c0    = r_lo0.c;
    assign o_w_d0    = r_lo0.d;
    assign o_w_v0    = r_lo0.v;
    assign o_w_pfn1  = r_lo1.pfn;
    assign o_w_c1    = r_lo1.c;
    assign o_w_d1    = r_lo1.d;
    assign o_w_v1    = r_lo1.v;

endmodule

// File: tb/tb_cp0_tlb_unit.sv
// tb_cp0_tlb_unit: directed bench for cp0_tlb_unit with a cycle-level reference model.
// Ports: none; drives the DUT at posedge+1 and checks at negedge.
module tb_cp0_tlb_unit;

    localparam int N = 16;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cmd_valid, flush, mtc0_we, exc_tlb;
    logic [1:0]  cmd_op;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata, badvaddr, rdata;
    logic        s_resp_valid, s_found;
    logic [3:0]  s_index;
    logic        cmd_ready, cmd_done, s_req, we, w_g;
    logic [18:0] s_vpn2, w_vpn2;
    logic [7:0]  s_asid, w_asid;
    logic [3:0]  r_index, w_index;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        w_d0, w_v0, w_d1, w_v1;

    tlb_ent_t tlb [N];
    tlb_ent_t cur;
    assign cur = tlb[r_index];

    cp0_tlb_unit #(.TLBNUM(N)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
        .o_cmd_ready(cmd_ready), .o_cmd_done(cmd_done),
        .i_flush(flush), .i_mtc0_we(mtc0_we),
        .i_cp0_waddr(waddr), .i_cp0_wdata(wdata),
        .i_cp0_raddr(raddr), .o_cp0_rdata(rdata),
        .i_exc_tlb(exc_tlb), .i_exc_badvaddr(badvaddr),
        .o_s_req(s_req), .o_s_vpn2(s_vpn2), .o_s_asid(s_asid),
        .i_s_resp_valid(s_resp_valid), .i_s_found(s_found),
        .i_s_index(s_index), .o_r_index(r_index),
        .i_r_vpn2(cur.vpn2), .i_r_asid(cur.asid), .i_r_g(cur.g),
        .i_r_pfn0(cur.pfn0), .i_r_c0(cur.c0),
        .i_r_d0(cur.d0), .i_r_v0(cur.v0),
        .i_r_pfn1(cur.pfn1), .i_r_c1(cur.c1),
        .i_r_d1(cur.d1), .i_r_v1(cur.v1),
        .o_we(we), .o_w_index(w_index),
        .o_w_vpn2(w_vpn2), .o_w_asid(w_asid), .o_w_g(w_g),
        .o_w_pfn0(w_pfn0), .o_w_c0(w_c0),
        .o_w_d0(w_d0), .o_w_v0(w_v0),
        .o_w_pfn1(w_pfn1), .o_w_c1(w_c1),
        .o_w_d1(w_d1), .o_w_v1(w_v1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: architectural registers plus the job in flight.
    // m_cmd = -1 when no job; m_step counts cycles since acceptance.
    logic        m_p;
    logic [3:0]  m_index, m_random, m_wired;
    logic [18:0] m_vpn2;
    logic [7:0]  m_asid;
    logic [31:0] m_lo0, m_lo1;
    int          m_cmd, m_step;
    bit          m_drain;
    bit          e_sreq, e_pdone, e_read, e_we, e_done, e_ready;

    function automatic logic [31:0] lo_word(int pfn, int c, int d,
                                            int v, int g);
        return 32'(pfn * 64 + c * 8 + d * 4 + v * 2 + g);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd0:    return 32'(m_p) * 32'h8000_0000 + 32'(m_index);
            5'd1:    return 32'(m_random);
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd6:    return 32'(m_wired);
            5'd10:   return 32'(m_vpn2) * 32'h2000 + 32'(m_asid);
            default: return 32'd0;
        endcase
    endfunction

    task automatic compute_exp();
        e_sreq  = (m_cmd == 0) && (m_step == 1) && !flush;
        e_pdone = (m_cmd == 0) && (m_step >= 2) && s_resp_valid && !flush;
        e_read  = (m_cmd == 1) && !flush;
        e_we    = (m_cmd >= 2) && !flush;
        e_done  = e_pdone || e_read || e_we;
        e_ready = (m_cmd < 0) && !m_drain;
    endtask

    always @(posedge clk) begin
        tlb_ent_t te;
        logic [3:0] n_rand;
        if (reset) begin
            m_p = 0; m_index = 0; m_random = 4'(N - 1); m_wired = 0;
            m_vpn2 = 0; m_asid = 0; m_lo0 = 0; m_lo1 = 0;
            m_cmd = -1; m_step = 0; m_drain = 0;
        end else begin
            compute_exp();
            te = tlb[m_index];
            if (mtc0_we && waddr == 5'd6) begin
                n_rand = 4'(N - 1);
                m_wired = wdata[3:0];
            end else if (m_random == m_wired) begin
                n_rand = 4'(N - 1);
            end else begin
                n_rand = m_random - 4'd1;
            end
            if (e_pdone) begin
                m_p = !s_found;
                if (s_found) m_index = s_index;
            end else if (mtc0_we && waddr == 5'd0) begin
                m_index = wdata[3:0];
            end
            if (exc_tlb) m_vpn2 = badvaddr[31:13];
            else if (e_read) m_vpn2 = te.vpn2;
            else if (mtc0_we && waddr == 5'd10) m_vpn2 = wdata[31:13];
            if (e_read) m_asid = te.asid;
            else if (mtc0_we && waddr == 5'd10) m_asid = wdata[7:0];
            if (e_read) begin
                m_lo0 = lo_word(int'(te.pfn0), int'(te.c0), int'(te.d0),
                                int'(te.v0), int'(te.g));
                m_lo1 = lo_word(int'(te.pfn1), int'(te.c1), int'(te.d1),
                                int'(te.v1), int'(te.g));
            end else begin
                if (mtc0_we && waddr == 5'd2) m_lo0 = wdata & 32'h03FF_FFFF;
                if (mtc0_we && waddr == 5'd3) m_lo1 = wdata & 32'h03FF_FFFF;
            end
            m_random = n_rand;
            if (m_drain) begin
                if (s_resp_valid) m_drain = 0;
            end else if (m_cmd < 0) begin
                if (cmd_valid && !flush) begin
                    m_cmd = int'(cmd_op);
                    m_step = 1;
                end
            end else if (m_cmd == 0 && m_step == 1) begin
                if (flush) m_cmd = -1;
                else m_step = 2;
            end else if (m_cmd == 0) begin
                if (s_resp_valid) m_cmd = -1;
                else if (flush) begin
                    m_cmd = -1;
                    m_drain = 1;
                end
            end else begin
                m_cmd = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            compute_exp();
            if (cmd_done) done_cnt++;
            chk("cyc_ready", cmd_ready, e_ready);
            chk("cyc_sreq", s_req, e_sreq);
            chk("cyc_we", we, e_we);
            chk("cyc_done", cmd_done, e_done);
            chk("cyc_rdata", rdata, model_read(raddr));
            chk("cyc_rindex", r_index, m_index);
            chk("cyc_skey", {s_vpn2, s_asid}, {m_vpn2, m_asid});
            if (e_we) begin
                chk("cyc_windex", w_index,
                    (m_cmd == 3) ? m_random : m_index);
                chk("cyc_whi", {w_vpn2, w_asid}, {m_vpn2, m_asid});
                chk("cyc_wlo0", {w_pfn0, w_c0, w_d0, w_v0, w_g},
                    {m_lo0[25:1], m_lo0[0] & m_lo1[0]});
                chk("cyc_wlo1", {w_pfn1, w_c1, w_d1, w_v1},
                    m_lo1[25:1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [4:0] a, input logic [31:0] exp,
                        input string nm);
        logic [4:0] saved;
        saved = raddr;
        raddr = a;
        #1;
        chk(nm, rdata, exp);
        raddr = saved;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1; waddr = a; wdata = d;
        tick();
        mtc0_we = 0;
    endtask

    int d0;

    initial begin
        for (int i = 0; i < N; i++) begin
            tlb[i] = '{vpn2: 19'(i * 3 + 1), asid: 8'(i + 16), g: i[0],
                       pfn0: 20'(i * 16 + 1), c0: 3'(i), d0: i[1], v0: i[2],
                       pfn1: 20'(i * 32 + 7), c1: 3'(i + 1), d1: i[2],
                       v1: i[0]};
        end
        tlb[5] = '{vpn2: 19'h12345, asid: 8'h3C, g: 1'b1,
                   pfn0: 20'hABCDE, c0: 3'd0, d0: 1'b0, v0: 1'b0,
                   pfn1: 20'h00111, c1: 3'd2, d1: 1'b1, v1: 1'b1};
        reset = 1; cmd_valid = 0; cmd_op = 0; flush = 0; mtc0_we = 0;
        exc_tlb = 0; waddr = 0; wdata = 0; raddr = 5'd1; badvaddr = 0;
        s_resp_valid = 0; s_found = 0; s_index = 0;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("rst_random", rdata, 32'd15);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_we", we, 0);
        peek(5'd0, 32'd0, "rst_index");
        tick();

        // TLBP hit, response three cycles after acceptance
        mtc0(5'd10, 32'h0040_2005);
        d0 = done_cnt;
        cmd_valid = 1; cmd_op = 2'd0;
        tick();
        cmd_valid = 0;
        @(negedge clk);
        chk("probe_sreq", s_req, 1);
        chk("probe_vpn2", s_vpn2, 19'h0201);
        chk("probe_asid", s_asid, 8'h05);
        tick(); tick();
        s_resp_valid = 1; s_found = 1; s_index = 4'd5;
        @(negedge clk);
        chk("probe_done", cmd_done, 1);
        tick();
        s_resp_valid = 0;
        @(negedge clk);
        peek(5'd0, 32'h0000_0005, "probe_hit_index");
        chk("probe_done_cnt", done_cnt - d0, 1);
        tick();

        // TLBP miss: P set, index kept
        cmd_valid = 1; cmd_op = 2'd0;
        tick();
        cmd_valid = 0;
        tick();
        s_resp_valid = 1; s_found = 0; s_index = 4'd9;
        tick();
        s_resp_valid = 0;
        @(negedge clk);
        peek(5'd0, 32'h8000_0005, "probe_miss");
        tick();

        // Wired = 4 and the Random walk
        mtc0(5'd6, 32'd4);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("rand_seq", rdata, (i < 12) ? 32'(15 - i) : 32'd15);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            repeat (k) tick();
            cmd_valid = 1; cmd_op = 2'd3;
            tick();
            cmd_valid = 0;
            @(negedge clk);
            chk("wr_we", we, 1);
            chk("wr_floor", w_index >= 4'd4, 1);
            tick();
        end

        // TLBR of entry 5
        cmd_valid = 1; cmd_op = 2'd1;
        tick();
        cmd_valid = 0;
        @(negedge clk);
        chk("tlbr_done", cmd_done, 1);
        chk("tlbr_rindex", r_index, 4'd5);
        tick();
        @(negedge clk);
        peek(5'd2, 32'h02AF_3781, "tlbr_lo0");
        peek(5'd3, 32'h0000_4457, "tlbr_lo1");
        peek(5'd10, 32'h2468_A03C, "tlbr_hi");
        tick();

        // flush against IDLE, WRITE and PROBE
        cmd_valid = 1; cmd_op = 2'd3; flush = 1;
        tick();
        cmd_valid = 0; flush = 0;
        @(negedge clk);
        chk("idle_flush_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_valid = 0; flush = 1;
        @(negedge clk);
        chk("flush_we", we, 0);
        chk("flush_wdone", cmd_done, 0);
        tick();
        flush = 0;
        cmd_valid = 1; cmd_op = 2'd0;
        tick();
        cmd_valid = 0; flush = 1;
        @(negedge clk);
        chk("flush_sreq", s_req, 0);
        tick();
        flush = 0;

        // flush in WAIT, late response drained
        mtc0(5'd0, 32'd3);
        mtc0(5'd10, 32'h0000_4000);
        d0 = done_cnt;
        cmd_valid = 1; cmd_op = 2'd0;
        tick();
        cmd_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        chk("drain_ready", cmd_ready, 0);
        tick();
        s_resp_valid = 1; s_found = 1; s_index = 4'd7;
        @(negedge clk);
        chk("drain_done", cmd_done, 0);
        tick();
        s_resp_valid = 0;
        @(negedge clk);
        peek(5'd0, 32'h8000_0003, "flush_index");
        chk("flush_no_done", done_cnt - d0, 0);
        tick();
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_valid = 0;
        @(negedge clk);
        chk("wi_we", we, 1);
        chk("wi_index", w_index, 4'd3);
        chk("wi_vpn2", w_vpn2, 19'd2);
        tick();

        // exception beats mtc0 for VPN2, ASID still from mtc0
        mtc0_we = 1; waddr = 5'd10; wdata = 32'h0000_0000;
        exc_tlb = 1; badvaddr = 32'hFFFF_E123;
        tick();
        mtc0_we = 0; exc_tlb = 0;
        @(negedge clk);
        peek(5'd10, 32'hFFFF_E000, "exc_hi");
        tick();

        // reset during WAIT; the stale response is ignored
        cmd_valid = 1; cmd_op = 2'd0;
        tick();
        cmd_valid = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        s_resp_valid = 1; s_found = 1; s_index = 4'd9;
        @(negedge clk);
        chk("rst2_ready", cmd_ready, 1);
        tick();
        s_resp_valid = 0;
        @(negedge clk);
        peek(5'd0, 32'd0, "rst2_index");
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_tlb_unit.md
# cp0_tlb_unit

CP0 TLB-management block for the MIPS pipeline, parametrised on TLB entry count. It holds Index, Random, Wired, EntryHi, EntryLo0 and EntryLo1, and serves mtc0/mfc0 to them. It sequences TLBP, TLBR, TLBWI and TLBWR against the TLB search, read and write ports through a request/response FSM, and supports abort on exception flush. It sits beside the WB-stage CP0 logic, which stalls on `cmd_ready`/`cmd_done`.

## Interface
- `TLBNUM`, 16 — TLB entry count, power of two, 2..64; `IDXW = $clog2(TLBNUM)` is derived, not overridable.
- `clk` in 1 — clock.
- `reset` in 1 — synchronous, active-high.
- `cmd_valid` in 1 — TLB instruction request.
- `cmd_op` in 2 — 0 = TLBP, 1 = TLBR, 2 = TLBWI, 3 = TLBWR.
- `cmd_ready` out 1 — high only in IDLE.
- `cmd_done` out 1 — one-cycle pulse when the command has completed its register/TLB update.
- `flush` in 1 — exception/eret flush; aborts any in-flight command.
- `mtc0_we` in 1 — mtc0 write enable.
- `cp0_waddr` in 5 — mtc0 register number.
- `cp0_wdata` in 32 — mtc0 data.
- `cp0_raddr` in 5 — mfc0 register number.
- `cp0_rdata` out 32 — combinational read data; 0 for unowned addresses.
- `exc_tlb` in 1 — TLB refill/invalid/modified exception commit.
- `exc_badvaddr` in 32 — faulting address for that exception.
- `s_req` out 1 — search request pulse.
- `s_vpn2` out 19, `s_asid` out 8 — search key, taken from EntryHi.
- `s_resp_valid` in 1 — search result valid, 1+ cycles after `s_req`.
- `s_found` in 1 — search hit.
- `s_index` in IDXW — index of the hit entry.
- `r_index` out IDXW — TLB read index, always equal to Index.
- `r_vpn2`, `r_asid`, `r_g`, `r_pfn0/1`, `r_c0/1`, `r_d0/1`, `r_v0/1` in — TLB read data, combinational from `r_index`.
- `we` out 1 — TLB write pulse.
- `w_index` out IDXW — TLB write index.
- `w_vpn2`, `w_asid`, `w_g`, `w_pfn0/1`, `w_c0/1`, `w_d0/1`, `w_v0/1` out — TLB write data.

## Operation
- Register numbers: Index = 0, Random = 1, EntryLo0 = 2, EntryLo1 = 3, Wired = 6, EntryHi = 10.
- Field layouts:
  - Index: P[31], Index[IDXW-1:0].
  - EntryHi: VPN2[31:13], ASID[7:0].
  - EntryLo: PFN[25:6], C[5:3], D[2], V[1], G[0].
  - Random and Wired: [IDXW-1:0].
  - All other bits read 0.
- Writability:
  - Random is read-only.
  - P is written only by TLBP; mtc0 to Index writes only the index field.
- Reset values: all registers 0 except Random = TLBNUM-1.
- Reset values of outputs: `cmd_ready` = 1; `cmd_done`, `s_req` and `we` = 0.
- Random:
  - Each cycle: if Random == Wired, load TLBNUM-1; otherwise decrement.
  - An mtc0 to Wired loads Wired and sets Random to TLBNUM-1 in the same cycle.
- FSM states: IDLE, PROBE, WAIT, READ, WRITE, DRAIN.
  - IDLE: on `cmd_valid`, TLBP goes to PROBE, TLBR to READ, and TLBWI/TLBWR to WRITE.
  - PROBE: assert `s_req` for one cycle, then go to WAIT.
  - WAIT: on `s_resp_valid`:
    - hit: P = 0 and Index = `s_index`;
    - miss: P = 1 and the index field is unchanged;
    - then pulse `cmd_done` and return to IDLE.
  - READ: capture the read data into EntryHi and EntryLo0/1; G0 = G1 = `r_g`. Pulse `cmd_done` and return to IDLE.
  - WRITE: assert `we`, with `w_index` = Index (TLBWI) or the current Random (TLBWR), and `w_g` = G0 & G1. Pulse `cmd_done` and return to IDLE.
  - All `w_*` outputs other than `w_index` mirror the registers continuously.
- Flush:
  - In PROBE, WRITE or READ: that state's outputs and updates are suppressed, and the FSM returns to IDLE.
  - In WAIT: go to DRAIN, which discards the next `s_resp_valid`, then returns to IDLE.
  - `cmd_done` is never asserted for an aborted command.
  - `cmd_valid` with `flush` in IDLE is ignored.
- `exc_tlb`: VPN2 = `exc_badvaddr[31:13]`; ASID is unchanged.
- Same-cycle write priority for a field: `exc_tlb` > command update (WAIT response, READ) > mtc0.

## Timing
- TLBP latency: accept at cycle 0; `s_req` at cycle 1; result update and `cmd_done` in the cycle of `s_resp_valid` (cycle 2 at the earliest). The register value is visible from the next cycle.
- TLBR and TLBWI/TLBWR: accept at cycle 0; update/`we` and `cmd_done` at cycle 1.
- `cmd_ready` is registered from state; back-to-back commands are spaced at least one IDLE cycle apart.
- `cp0_rdata` is combinational on `cp0_raddr` and returns pre-update values in an update cycle.
- Reset mid-operation returns to IDLE and applies reset values the next cycle. A pending TLB response after reset is ignored.

## Structure
- Package `cp0_tlb_pkg`: CP0 register-number constants, `cmd_op` encodings, FSM state enum, EntryLo field struct.
- One sub-module, `cp0_random`: the Random/Wired counter, parametrised on TLBNUM.

## Test plan
- Reset -> Random = 15, Index = 0, `cmd_ready` = 1; mfc0 of register 1 returns 15.
- mtc0 EntryHi = 0x0040_2005, TLBP, response hit with index 5 after 3 cycles -> `s_vpn2` = 0x0201, `s_asid` = 0x05; `cp0_rdata(0)` = 0x0000_0005; exactly one `cmd_done`.
- TLBP with miss -> `cp0_rdata(0)` = 0x8000_0005, index unchanged.
- mtc0 Wired = 4, run 12 cycles -> Random sequence 15..4,15; a TLBWR in any cycle writes `w_index` equal to the current Random and never below 4.
- TLB read entry 5 returns pfn0 = 0xABCDE, g = 1; TLBR -> EntryLo0 = 0x02AF_3781 (C, D and V = 0), EntryLo1.G = 1.
- TLBP, then `flush` in WAIT -> the late response is dropped, Index unchanged, no `cmd_done`; a following TLBWI works normally.
